// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access sequencer.
// Used by csr_ctrl and csr_alu.
package csr_pkg;

  typedef enum logic [2:0] {
    OP_RW    = 3'd0,
    OP_RS    = 3'd1,
    OP_RC    = 3'd2,
    OP_ECALL = 3'd3,
    OP_MRET  = 3'd4
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_TRAP  = 3'd3,
    ST_RESP  = 3'd4
  } csr_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned MCAUSE_ECALL_M = 11;

  // True for the CSR addresses implemented by the core's register file.
  function automatic logic csr_addr_known(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
           (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational new-value computation for csrrw/csrrs/csrrc.
module csr_alu
  import csr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  csr_op_e            op_i,
  input  logic [WIDTH-1:0]   old_i,
  input  logic [WIDTH-1:0]   src_i,
  output logic [WIDTH-1:0]   new_o
);

  always_comb begin
    new_o = old_i;
    unique case (op_i)
      OP_RW:   new_o = src_i;
      OP_RS:   new_o = old_i | src_i;
      OP_RC:   new_o = old_i & ~src_i;
      default: new_o = old_i;
    endcase
  end

endmodule

// File: rtl/csr_ctrl.sv
// Multi-cycle CSR access sequencer (READ / WRITE / TRAP / RESP).
// Optional address filtering with illegal flag: define CSR_ADDR_CHECK_EN.
module csr_ctrl
  import csr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  csr_op_e            in_op,
  input  logic               in_imm,
  input  logic [11:0]        in_addr,
  input  logic [WIDTH-1:0]   in_rs1_data,
  input  logic [4:0]         in_zimm,
  input  logic               in_src_zero,
  input  logic [WIDTH-1:0]   in_pc,
  output logic [11:0]        csr_addr,
  output logic               csr_wen,
  output logic [WIDTH-1:0]   csr_wdata,
  input  logic [WIDTH-1:0]   csr_rdata,
  output logic               csr_ecall,
  output logic [WIDTH-1:0]   csr_pc,
  input  logic [WIDTH-1:0]   csr_mtvec,
  input  logic [WIDTH-1:0]   csr_mepc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_rd_data,
  output logic               out_redirect,
  output logic [WIDTH-1:0]   out_redirect_pc
`ifdef CSR_ADDR_CHECK_EN
  ,
  output logic               out_illegal
`endif
);

  csr_state_e        state_q, state_d;
  csr_op_e           op_q, op_d;
  logic [11:0]       addr_q, addr_d;
  logic [WIDTH-1:0]  src_q, src_d;
  logic              src_zero_q, src_zero_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  rd_q, rd_d;
  logic              redir_q, redir_d;
  logic [WIDTH-1:0]  rpc_q, rpc_d;
`ifdef CSR_ADDR_CHECK_EN
  logic              illegal_q, illegal_d;
`endif

  logic [WIDTH-1:0]  in_src;
  logic [WIDTH-1:0]  alu_new;

  assign in_src = in_imm ? {{(WIDTH-5){1'b0}}, in_zimm} : in_rs1_data;

  csr_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i  (op_q),
    .old_i (csr_rdata),
    .src_i (src_q),
    .new_o (alu_new)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Instruction/result holding registers need no reset: outputs are gated by state.
  always_ff @(posedge clk) begin
    op_q       <= op_d;
    addr_q     <= addr_d;
    src_q      <= src_d;
    src_zero_q <= src_zero_d;
    pc_q       <= pc_d;
    wdata_q    <= wdata_d;
    rd_q       <= rd_d;
    redir_q    <= redir_d;
    rpc_q      <= rpc_d;
`ifdef CSR_ADDR_CHECK_EN
    illegal_q  <= illegal_d;
`endif
  end

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    addr_d          = addr_q;
    src_d           = src_q;
    src_zero_d      = src_zero_q;
    pc_d            = pc_q;
    wdata_d         = wdata_q;
    rd_d            = rd_q;
    redir_d         = redir_q;
    rpc_d           = rpc_q;
`ifdef CSR_ADDR_CHECK_EN
    illegal_d       = illegal_q;
    out_illegal     = 1'b0;
`endif
    in_ready        = 1'b0;
    csr_addr        = '0;
    csr_wen         = 1'b0;
    csr_wdata       = '0;
    csr_ecall       = 1'b0;
    csr_pc          = '0;
    out_valid       = 1'b0;
    out_rd_data     = '0;
    out_redirect    = 1'b0;
    out_redirect_pc = '0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d       = in_op;
          addr_d     = in_addr;
          src_d      = in_src;
          src_zero_d = in_src_zero;
          pc_d       = in_pc;
          rd_d       = '0;
          redir_d    = 1'b0;
          rpc_d      = '0;
`ifdef CSR_ADDR_CHECK_EN
          illegal_d  = 1'b0;
`endif
          unique case (in_op)
            OP_RW, OP_RS, OP_RC: begin
              state_d = ST_READ;
`ifdef CSR_ADDR_CHECK_EN
              if (!csr_addr_known(in_addr)) begin
                illegal_d = 1'b1;
                state_d   = ST_RESP;
              end
`endif
            end
            OP_ECALL: begin
              redir_d = 1'b1;
              state_d = ST_TRAP;
            end
            OP_MRET: begin
              redir_d = 1'b1;
              rpc_d   = csr_mepc;
              state_d = ST_RESP;
            end
            default: state_d = ST_RESP;
          endcase
        end
      end
      ST_READ: begin
        csr_addr = addr_q;
        rd_d     = csr_rdata;
        wdata_d  = alu_new;
        // Set/clear with a zero source must not write (side-effect free read).
        if (op_q == OP_RW || !src_zero_q) state_d = ST_WRITE;
        else                              state_d = ST_RESP;
      end
      ST_WRITE: begin
        csr_addr  = addr_q;
        csr_wen   = 1'b1;
        csr_wdata = wdata_q;
        state_d   = ST_RESP;
      end
      ST_TRAP: begin
        csr_ecall = 1'b1;
        csr_pc    = pc_q;
        rpc_d     = csr_mtvec;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        out_valid       = 1'b1;
        out_rd_data     = rd_q;
        out_redirect    = redir_q;
        out_redirect_pc = rpc_q;
`ifdef CSR_ADDR_CHECK_EN
        out_illegal     = illegal_q;
`endif
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed scoreboard bench for csr_ctrl.
module tb_csr_ctrl;
  import csr_pkg::*;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  csr_op_e           in_op;
  logic              in_imm;
  logic [11:0]       in_addr;
  logic [WIDTH-1:0]  in_rs1_data;
  logic [4:0]        in_zimm;
  logic              in_src_zero;
  logic [WIDTH-1:0]  in_pc;
  logic [11:0]       csr_addr;
  logic              csr_wen;
  logic [WIDTH-1:0]  csr_wdata;
  logic [WIDTH-1:0]  csr_rdata;
  logic              csr_ecall;
  logic [WIDTH-1:0]  csr_pc;
  logic [WIDTH-1:0]  csr_mtvec;
  logic [WIDTH-1:0]  csr_mepc;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_rd_data;
  logic              out_redirect;
  logic [WIDTH-1:0]  out_redirect_pc;
`ifdef CSR_ADDR_CHECK_EN
  logic              out_illegal;
`endif

  // Single-entry CSR file model: only file_addr returns file_val.
  logic [11:0]       file_addr;
  logic [WIDTH-1:0]  file_val;
  assign csr_rdata = (csr_addr == file_addr) ? file_val : 32'hBAD0_BAD0;

  always #5 clk = ~clk;

  csr_ctrl #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_op           (in_op),
    .in_imm          (in_imm),
    .in_addr         (in_addr),
    .in_rs1_data     (in_rs1_data),
    .in_zimm         (in_zimm),
    .in_src_zero     (in_src_zero),
    .in_pc           (in_pc),
    .csr_addr        (csr_addr),
    .csr_wen         (csr_wen),
    .csr_wdata       (csr_wdata),
    .csr_rdata       (csr_rdata),
    .csr_ecall       (csr_ecall),
    .csr_pc          (csr_pc),
    .csr_mtvec       (csr_mtvec),
    .csr_mepc        (csr_mepc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_rd_data     (out_rd_data),
    .out_redirect    (out_redirect),
    .out_redirect_pc (out_redirect_pc)
`ifdef CSR_ADDR_CHECK_EN
    ,
    .out_illegal     (out_illegal)
`endif
  );

  typedef struct packed {
    logic [31:0] rd;
    logic        redir;
    logic [31:0] rpc;
  } resp_t;

  resp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accept edge, then keep in_valid high
  // with garbage fields that the busy sequencer must ignore.
  task automatic issue(input csr_op_e op, input logic imm, input logic [11:0] addr,
                       input logic [31:0] rs1, input logic [4:0] zimm,
                       input logic sz, input logic [31:0] pc);
    check("in_ready_before_accept", 32'(in_ready), 32'h1);
    in_op       = op;
    in_imm      = imm;
    in_addr     = addr;
    in_rs1_data = rs1;
    in_zimm     = zimm;
    in_src_zero = sz;
    in_pc       = pc;
    in_valid    = 1'b1;
    tick();
    in_op       = OP_RC;
    in_imm      = 1'b0;
    in_addr     = 12'h7FF;
    in_rs1_data = 32'hDEAD_BEEF;
    in_zimm     = 5'h1F;
    in_src_zero = 1'b0;
    in_pc       = 32'h0000_1234;
    check("in_ready_busy", 32'(in_ready), 32'h0);
  endtask

  // Called in the cycle the response is due; completes the handshake.
  task automatic expect_resp(input string tag);
    resp_t e;
    check({tag, "_valid"}, 32'(out_valid), 32'h1);
    check({tag, "_wen_idle"}, 32'(csr_wen), 32'h0);
`ifdef CSR_ADDR_CHECK_EN
    check({tag, "_illegal"}, 32'(out_illegal), 32'h0);
`endif
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_scoreboard: observed empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rd_data"}, out_rd_data, e.rd);
      check({tag, "_redirect"}, 32'(out_redirect), 32'(e.redir));
      check({tag, "_redirect_pc"}, out_redirect_pc, e.rpc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check({tag, "_valid_drop"}, 32'(out_valid), 32'h0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_op       = OP_RW;
    in_imm      = 1'b0;
    in_addr     = '0;
    in_rs1_data = '0;
    in_zimm     = '0;
    in_src_zero = 1'b0;
    in_pc       = '0;
    csr_mtvec   = '0;
    csr_mepc    = '0;
    out_ready   = 1'b1;
    file_addr   = '0;
    file_val    = '0;
    tick();
    tick();

    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_csr_wen", 32'(csr_wen), 32'h0);
    check("rst_csr_ecall", 32'(csr_ecall), 32'h0);
    check("rst_csr_addr", 32'(csr_addr), 32'h0);
    check("rst_csr_wdata", csr_wdata, 32'h0);
    check("rst_redirect", 32'(out_redirect), 32'h0);
    check("rst_rd_data", out_rd_data, 32'h0);
    rst = 1'b0;
    tick();

    // csrrw mtvec
    file_addr = CSR_MTVEC;
    file_val  = 32'h0000_0000;
    exp_q.push_back('{rd: 32'h0, redir: 1'b0, rpc: 32'h0});
    issue(OP_RW, 1'b0, CSR_MTVEC, 32'h8000_0100, 5'h0, 1'b0, 32'h8000_0000);
    check("rw_read_addr", 32'(csr_addr), 32'(CSR_MTVEC));
    check("rw_read_nowen", 32'(csr_wen), 32'h0);
    check("rw_read_novalid", 32'(out_valid), 32'h0);
    tick();
    check("rw_wen", 32'(csr_wen), 32'h1);
    check("rw_write_addr", 32'(csr_addr), 32'(CSR_MTVEC));
    check("rw_wdata", csr_wdata, 32'h8000_0100);
    tick();
    expect_resp("rw");

    // csrrs mstatus, writing
    file_addr = CSR_MSTATUS;
    file_val  = 32'h0000_0008;
    exp_q.push_back('{rd: 32'h8, redir: 1'b0, rpc: 32'h0});
    issue(OP_RS, 1'b0, CSR_MSTATUS, 32'h0000_1800, 5'h0, 1'b0, 32'h8000_0004);
    check("rs_read_addr", 32'(csr_addr), 32'(CSR_MSTATUS));
    tick();
    check("rs_wen", 32'(csr_wen), 32'h1);
    check("rs_wdata", csr_wdata, 32'h0000_1808);
    tick();
    expect_resp("rs");

    // csrrs mstatus with x0 source: read only
    exp_q.push_back('{rd: 32'h8, redir: 1'b0, rpc: 32'h0});
    issue(OP_RS, 1'b0, CSR_MSTATUS, 32'h0000_0000, 5'h0, 1'b1, 32'h8000_0008);
    check("rs0_read_addr", 32'(csr_addr), 32'(CSR_MSTATUS));
    check("rs0_read_nowen", 32'(csr_wen), 32'h0);
    tick();
    expect_resp("rs0");

    // csrrci mcause, zimm=3; rs1 garbage must be ignored
    file_addr = CSR_MCAUSE;
    file_val  = 32'h0000_000F;
    exp_q.push_back('{rd: 32'hF, redir: 1'b0, rpc: 32'h0});
    issue(OP_RC, 1'b1, CSR_MCAUSE, 32'hFFFF_FFFF, 5'h3, 1'b0, 32'h8000_000C);
    tick();
    check("rci_wen", 32'(csr_wen), 32'h1);
    check("rci_wdata", csr_wdata, 32'h0000_000C);
    tick();
    expect_resp("rci");

    // ecall
    csr_mtvec = 32'h8000_0200;
    exp_q.push_back('{rd: 32'h0, redir: 1'b1, rpc: 32'h8000_0200});
    issue(OP_ECALL, 1'b0, 12'h000, 32'h0, 5'h0, 1'b1, 32'h8000_0040);
    check("ecall_strobe", 32'(csr_ecall), 32'h1);
    check("ecall_pc", csr_pc, 32'h8000_0040);
    check("ecall_addr", 32'(csr_addr), 32'h0);
    check("ecall_nowen", 32'(csr_wen), 32'h0);
    tick();
    csr_mtvec = 32'h0000_0000;
    check("ecall_strobe_drop", 32'(csr_ecall), 32'h0);
    expect_resp("ecall");

    // mret with downstream stalled for 3 cycles; mepc changes after accept
    csr_mepc  = 32'h8000_0044;
    out_ready = 1'b0;
    exp_q.push_back('{rd: 32'h0, redir: 1'b1, rpc: 32'h8000_0044});
    issue(OP_MRET, 1'b0, 12'h000, 32'h0, 5'h0, 1'b1, 32'h8000_0300);
    csr_mepc = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      check("mret_hold_valid", 32'(out_valid), 32'h1);
      check("mret_hold_pc", out_redirect_pc, 32'h8000_0044);
      check("mret_hold_in_ready", 32'(in_ready), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    expect_resp("mret");

    // reset while a writing op is in READ
    file_addr = CSR_MTVEC;
    file_val  = 32'h0000_0000;
    issue(OP_RW, 1'b0, CSR_MTVEC, 32'h1111_1111, 5'h0, 1'b0, 32'h8000_0010);
    check("rstmid_read_addr", 32'(csr_addr), 32'(CSR_MTVEC));
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    check("rstmid_in_ready", 32'(in_ready), 32'h1);
    check("rstmid_wen", 32'(csr_wen), 32'h0);
    check("rstmid_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_after_wen", 32'(csr_wen), 32'h0);
      check("rstmid_after_valid", 32'(out_valid), 32'h0);
      check("rstmid_after_in_ready", 32'(in_ready), 32'h1);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
